// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
//  tx_state_e : transmitter FSM states
//  parity_e   : parity mode encoding used by the PARITY parameter
//  frame_clks : clocks occupied by one complete frame on the line
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    // Start + data + optional parity + stop bits, each BAUD_DIV clocks long.
    function automatic int unsigned frame_clks(input int unsigned data_w,
                                               input int unsigned parity,
                                               input int unsigned stop_bits,
                                               input int unsigned baud_div);
        int unsigned par_bits;
        par_bits = (parity != 0) ? 32'd1 : 32'd0;
        return (32'd1 + data_w + par_bits + stop_bits) * baud_div;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO holding words waiting to be serialised.
//  clk, rst : clock, synchronous active-high reset (clears pointers and count)
//  push/din : enqueue din when not full
//  pop/dout : dequeue head; dout is the head word, valid while !empty
//  full, empty, count : registered occupancy status
module sync_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              full_q;
    logic              empty_q;
    logic              push_ok_c;
    logic              pop_ok_c;

    // A push while full is dropped even if a pop happens in the same cycle.
    assign push_ok_c = push && !full_q;
    assign pop_ok_c  = pop && !empty_q;

    // Occupancy update.
    always_comb begin
        count_d = count_q;
        case ({push_ok_c, pop_ok_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers, count and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst && push_ok_c) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: queues words in a FIFO and sends them as
// contiguous frames (start, DATA_W bits LSB first, optional parity, stop bits).
//  clk, rst       : clock, synchronous active-high reset
//  wr_en, tx_data : push tx_data into the FIFO when not full
//  full, empty    : FIFO status
//  count          : words queued, excluding the frame in flight
//  busy           : a frame is in flight
//  tx_done        : one-clock pulse at the end of each frame's last stop bit
//  TX             : serial line, idles high
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned BAUD_DIV  = 2604,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        tx_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     tx_done,
    output logic                     TX
);

    localparam int unsigned BAUD_W   = $clog2(BAUD_DIV);
    localparam int unsigned BIT_W    = $clog2(DATA_W);
    localparam parity_e     PAR_MODE = parity_e'(2'(PARITY));
    localparam bit          HAS_PAR  = (PAR_MODE != PAR_NONE);

    tx_state_e          state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               stop_q, stop_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               par_q, par_d;
    logic               tx_q;
    logic               busy_q;
    logic               end_q;
    logic               done_q;

    logic               tx_c;
    logic               pop_c;
    logic               frame_end_c;
    logic               baud_last_c;
    logic               stop_last_c;
    logic [DATA_W-1:0]  fifo_dout;
    logic               fifo_empty;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .pop   (pop_c),
        .din   (tx_data),
        .dout  (fifo_dout),
        .full  (full),
        .empty (fifo_empty),
        .count (count)
    );

    assign baud_last_c = (baud_q == BAUD_W'(BAUD_DIV - 1));
    assign stop_last_c = (STOP_BITS == 1) || stop_q;

    // Next state, counters, shift register and the line level for this bit slot.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        stop_d      = stop_q;
        shift_d     = shift_q;
        par_d       = par_q;
        pop_c       = 1'b0;
        frame_end_c = 1'b0;
        tx_c        = 1'b1;

        if (state_q != IDLE) begin
            baud_d = baud_last_c ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                stop_d = 1'b0;
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    shift_d = fifo_dout;
                    par_d   = (PAR_MODE == PAR_ODD) ? ~^fifo_dout : ^fifo_dout;
                    state_d = START;
                end
            end

            START: begin
                tx_c = 1'b0;
                if (baud_last_c) begin
                    state_d = DATA;
                end
            end

            DATA: begin
                tx_c = shift_q[0];
                if (baud_last_c) begin
                    shift_d = {1'b0, shift_q[DATA_W-1:1]};
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        bit_d   = '0;
                        state_d = HAS_PAR ? uart_pkg::PARITY : STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end

            uart_pkg::PARITY: begin
                tx_c = par_q;
                if (baud_last_c) begin
                    state_d = STOP;
                end
            end

            STOP: begin
                tx_c = 1'b1;
                if (baud_last_c) begin
                    if (stop_last_c) begin
                        stop_d      = 1'b0;
                        frame_end_c = 1'b1;
                        // Chain straight into the next frame when more words wait.
                        if (!fifo_empty) begin
                            pop_c   = 1'b1;
                            shift_d = fifo_dout;
                            par_d   = (PAR_MODE == PAR_ODD) ? ~^fifo_dout : ^fifo_dout;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. The line and done pulse are registered from
    // the current state, so TX trails the FSM by one clock; done is delayed by
    // two so that it lines up with the final stop clock leaving the TX flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            end_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_c;
            busy_q  <= (state_d != IDLE);
            end_q   <= frame_end_c;
            done_q  <= end_q;
        end
    end

    assign empty   = fifo_empty;
    assign busy    = busy_q;
    assign tx_done = done_q;
    assign TX      = tx_q;

endmodule
